// File: rtl/iir_ema_mc.sv
// Per-channel single-pole IIR baseline tracker with block-average warm-up seeding.
// One-cycle registered output; accepts a sample every cycle and never stalls.
module iir_ema_mc #(
  parameter int DATA_W    = 14,
  parameter int NCH       = 4,
  parameter int CH_W      = 2,
  parameter int KMAX      = 15,
  parameter int K_DEFAULT = 12,
  localparam int KW       = $clog2(KMAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adc_valid,
  input  logic [CH_W-1:0]   adc_ch,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              clr,
  input  logic [KW-1:0]     k_cfg,
  output logic [KW-1:0]     k_cur,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] avg_whole,
  output logic [KMAX-1:0]   avg_frac,
  output logic              ch_err
);

  localparam int SW = DATA_W + KMAX;
  localparam logic [CH_W:0] NCH_C = (CH_W + 1)'(NCH);
  localparam logic [KMAX:0] ONE_C = (KMAX + 1)'(1);
  localparam logic [KW:0]   KMAX_W = (KW + 1)'(KMAX);

  logic          run_q [NCH];
  logic [KMAX:0] cnt_q [NCH];
  logic [SW-1:0] sum_q [NCH];
  logic [SW-1:0] s_q   [NCH];
  logic [KW-1:0] k_q;

  logic          ch_ok, acc, bad, warm_done, emit;
  logic          run_cur;
  logic [KMAX:0] cnt_cur, cnt_last;
  logic [SW-1:0] sum_cur, s_cur, sum_nxt, seed, s_run, s_nxt;
  logic signed [SW:0] d, d_sh;

  assign k_cur = k_q;
  assign ch_ok = {1'b0, adc_ch} < NCH_C;
  assign acc   = adc_valid & ~clr & ch_ok;
  assign bad   = adc_valid & ~clr & ~ch_ok;

  always_comb begin
    run_cur = 1'b0;
    cnt_cur = '0;
    sum_cur = '0;
    s_cur   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (adc_ch == CH_W'(i)) begin
        run_cur = run_q[i];
        cnt_cur = cnt_q[i];
        sum_cur = sum_q[i];
        s_cur   = s_q[i];
      end
    end
  end

  // Warm-up ends on the 2^K-th sample; the block sum is rescaled to KMAX fraction bits.
  assign cnt_last  = (ONE_C << k_q) - ONE_C;
  assign warm_done = cnt_cur == cnt_last;
  assign sum_nxt   = sum_cur + SW'(adc_data);
  assign seed      = sum_nxt << (KW'(KMAX) - k_q);

  assign d     = $signed({1'b0, adc_data, {KMAX{1'b0}}}) - $signed({1'b0, s_cur});
  assign d_sh  = d >>> k_q;
  assign s_run = s_cur + d_sh[SW-1:0];
  assign s_nxt = run_cur ? s_run : seed;
  assign emit  = acc & (run_cur | warm_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        run_q[i] <= 1'b0;
        cnt_q[i] <= '0;
        sum_q[i] <= '0;
        s_q[i]   <= '0;
      end
      k_q <= KW'(K_DEFAULT);
    end else if (clr) begin
      for (int i = 0; i < NCH; i++) begin
        run_q[i] <= 1'b0;
        cnt_q[i] <= '0;
        sum_q[i] <= '0;
        s_q[i]   <= '0;
      end
      k_q <= ({1'b0, k_cfg} > KMAX_W) ? KW'(KMAX) : k_cfg;
    end else if (acc) begin
      for (int i = 0; i < NCH; i++) begin
        if (adc_ch == CH_W'(i)) begin
          if (run_cur) begin
            s_q[i] <= s_run;
          end else if (warm_done) begin
            s_q[i]   <= seed;
            run_q[i] <= 1'b1;
            cnt_q[i] <= '0;
            sum_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_cur + ONE_C;
            sum_q[i] <= sum_nxt;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ch_err    <= 1'b0;
      out_ch    <= '0;
      avg_whole <= '0;
      avg_frac  <= '0;
    end else begin
      out_valid <= emit;
      ch_err    <= bad;
      if (emit) begin
        out_ch    <= adc_ch;
        avg_whole <= s_nxt[SW-1:KMAX];
        avg_frac  <= s_nxt[KMAX-1:0];
      end
    end
  end

endmodule

// File: tb/tb_iir_ema_mc.sv
// Directed bench for iir_ema_mc with an expected-result queue popped on each out_valid.
module tb_iir_ema_mc;

  localparam int DATA_W = 14;
  localparam int NCH    = 4;
  localparam int CH_W   = 3;
  localparam int KMAX   = 15;
  localparam int KW     = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              adc_valid;
  logic [CH_W-1:0]   adc_ch;
  logic [DATA_W-1:0] adc_data;
  logic              clr;
  logic [KW-1:0]     k_cfg;
  logic [KW-1:0]     k_cur;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] avg_whole;
  logic [KMAX-1:0]   avg_frac;
  logic              ch_err;

  typedef struct {
    int ch;
    int w;
    int f;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  iir_ema_mc #(
    .DATA_W(DATA_W), .NCH(NCH), .CH_W(CH_W), .KMAX(KMAX), .K_DEFAULT(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .adc_valid(adc_valid), .adc_ch(adc_ch),
    .adc_data(adc_data), .clr(clr), .k_cfg(k_cfg), .k_cur(k_cur),
    .out_valid(out_valid), .out_ch(out_ch), .avg_whole(avg_whole),
    .avg_frac(avg_frac), .ch_err(ch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout observed=stuck expected=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input int ch, input int data,
                      input bit ev, input int ew, input int ef, input bit eerr);
    exp_t e;
    @(negedge clk);
    adc_valid = v;
    adc_ch    = CH_W'(ch);
    adc_data  = DATA_W'(data);
    clr       = 1'b0;
    if (ev) begin
      e.ch = ch; e.w = ew; e.f = ef;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    adc_valid = 1'b0;
    chk("out_valid", out_valid, ev);
    chk("ch_err", ch_err, eerr);
    if (out_valid) begin
      chk("sb_level", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_ch", out_ch, e.ch);
        chk("avg_whole", avg_whole, e.w);
        chk("avg_frac", avg_frac, e.f);
      end
    end
  endtask

  task automatic do_clr(input int k, input int exp_k, input bit v, input int data);
    @(negedge clk);
    clr       = 1'b1;
    k_cfg     = KW'(k);
    adc_valid = v;
    adc_ch    = '0;
    adc_data  = DATA_W'(data);
    @(posedge clk);
    #1;
    clr       = 1'b0;
    adc_valid = 1'b0;
    chk("clr_out_valid", out_valid, 0);
    chk("k_cur", k_cur, exp_k);
  endtask

  initial begin
    longint sm, dd;
    int     prev_w;

    rst_n = 1'b0; adc_valid = 1'b0; adc_ch = '0; adc_data = '0; clr = 1'b0; k_cfg = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_avg_whole", avg_whole, 0);
    chk("rst_avg_frac", avg_frac, 0);
    chk("rst_ch_err", ch_err, 0);
    chk("rst_k_cur", k_cur, 12);
    @(negedge clk);
    rst_n = 1'b1;

    // warm-up seeding
    do_clr(2, 2, 0, 0);
    step(1, 0, 10, 0, 0, 0, 0);
    step(1, 0, 11, 0, 0, 0, 0);
    step(1, 0, 12, 0, 0, 0, 0);
    step(1, 0, 13, 1, 11, 16384, 0);

    // IIR step and floor rounding
    do_clr(2, 2, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 100, 0, 0, 0, 0);
    step(1, 0, 100, 1, 100, 0, 0);
    step(1, 0, 104, 1, 101, 0, 0);
    step(1, 0, 102, 1, 101, 8192, 0);
    step(1, 0, 0, 1, 75, 30720, 0);
    do_clr(2, 2, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 100, 0, 0, 0, 0);
    step(1, 0, 100, 1, 100, 0, 0);
    step(1, 0, 99, 1, 99, 24576, 0);

    // channel independence
    do_clr(2, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1000, 0, 0, 0, 0);
      step(1, 3, 50, 0, 0, 0, 0);
    end
    step(1, 0, 1000, 1, 1000, 0, 0);
    step(1, 3, 50, 1, 50, 0, 0);
    step(1, 0, 1004, 1, 1001, 0, 0);
    step(1, 3, 50, 1, 50, 0, 0);

    // K=0, then the largest K
    do_clr(0, 0, 0, 0);
    step(1, 1, 7, 1, 7, 0, 0);
    step(1, 1, 9, 1, 9, 0, 0);
    do_clr(15, 15, 0, 0);
    for (int i = 0; i < 32767; i++) step(1, 2, 5, 0, 0, 0, 0);
    step(1, 2, 5, 1, 5, 0, 0);

    // clr with a coincident sample restarts warm-up without counting it
    do_clr(2, 2, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 20, 0, 0, 0, 0);
    do_clr(2, 2, 1, 20);
    for (int i = 0; i < 3; i++) step(1, 0, 20, 0, 0, 0, 0);
    step(1, 0, 20, 1, 20, 0, 0);

    // out-of-range channel; idle cycle holds outputs
    step(1, 5, 77, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("hold_avg_whole", avg_whole, 20);

    // reset mid warm-up
    do_clr(2, 2, 0, 0);
    step(1, 0, 30, 0, 0, 0, 0);
    step(1, 0, 30, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_avg_whole", avg_whole, 0);
    chk("mid_rst_avg_frac", avg_frac, 0);
    chk("mid_rst_out_ch", out_ch, 0);
    chk("mid_rst_k_cur", k_cur, 12);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 0, 30, 0, 0, 0, 0);

    // full-scale stress against a floor-rounding model
    do_clr(3, 3, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 2, 16383, 0, 0, 0, 0);
    step(1, 2, 16383, 1, 16383, 0, 0);
    sm = longint'(16383) << 15;
    for (int i = 0; i < 92; i++) step(1, 2, 16383, 1, 16383, 0, 0);
    prev_w = 16383;
    for (int i = 0; i < 200; i++) begin
      dd = 0 - sm;
      sm = sm + (dd >>> 3);
      step(1, 2, 0, 1, int'(sm >>> 15), int'(sm & 64'd32767), 0);
      chk("monotonic", avg_whole <= DATA_W'(prev_w), 1);
      prev_w = int'(avg_whole);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
